// File: rtl/imager_roi_stats.sv
// imager_roi_stats: per-frame geometry measurement and ROI pixel statistics on a dat/fv/lv stream.
// Latency: results and stats_valid appear 1 cycle after the staged fv fall (2 cycles after fv falls at the port).
// Backpressure: none; the stream is consumed every cycle and each completed frame overwrites the results.
module imager_roi_stats #(
  parameter int DATA_WIDTH     = 10,
  parameter int NUM_ROWS_WIDTH = 12,
  parameter int NUM_COLS_WIDTH = 12,
  parameter int SUM_WIDTH      = DATA_WIDTH + NUM_ROWS_WIDTH + NUM_COLS_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     enable,
  input  logic                                     fv,
  input  logic                                     lv,
  input  logic [DATA_WIDTH-1:0]                    dat,
  input  logic [NUM_ROWS_WIDTH-1:0]                roi_row_start,
  input  logic [NUM_ROWS_WIDTH-1:0]                roi_row_end,
  input  logic [NUM_COLS_WIDTH-1:0]                roi_col_start,
  input  logic [NUM_COLS_WIDTH-1:0]                roi_col_end,
  output logic                                     stats_valid,
  output logic [NUM_ROWS_WIDTH-1:0]                frame_rows,
  output logic [NUM_COLS_WIDTH-1:0]                frame_cols,
  output logic                                     geom_err,
  output logic [SUM_WIDTH-1:0]                     roi_sum,
  output logic [DATA_WIDTH-1:0]                    roi_min,
  output logic [DATA_WIDTH-1:0]                    roi_max,
  output logic [NUM_ROWS_WIDTH+NUM_COLS_WIDTH-1:0] roi_count,
  output logic [15:0]                              frame_count
);

  localparam int CNT_WIDTH = NUM_ROWS_WIDTH + NUM_COLS_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_FRAME = 2'd2;

  localparam logic [NUM_ROWS_WIDTH-1:0] ROW_MAX = '1;
  localparam logic [NUM_COLS_WIDTH-1:0] COL_MAX = '1;
  localparam logic [DATA_WIDTH-1:0]     DAT_MAX = '1;

  // Input stage and its previous-cycle copy
  logic                  fv_s1;
  logic                  lv_s1;
  logic [DATA_WIDTH-1:0] dat_s1;
  logic                  fv_d;
  logic                  lv_d;

  logic [1:0] state;

  // Per-frame accumulators
  logic [NUM_ROWS_WIDTH-1:0] row_cnt;
  logic [NUM_COLS_WIDTH-1:0] col_cnt;
  logic [NUM_COLS_WIDTH-1:0] first_len;
  logic                      first_seen;
  logic                      gerr_acc;
  logic [SUM_WIDTH-1:0]      sum_acc;
  logic [CNT_WIDTH-1:0]      cnt_acc;
  logic [DATA_WIDTH-1:0]     min_acc;
  logic [DATA_WIDTH-1:0]     max_acc;

  // ROI bounds frozen at frame start
  logic [NUM_ROWS_WIDTH-1:0] sh_row_start;
  logic [NUM_ROWS_WIDTH-1:0] sh_row_end;
  logic [NUM_COLS_WIDTH-1:0] sh_col_start;
  logic [NUM_COLS_WIDTH-1:0] sh_col_end;

  // Event decode on staged signals
  logic fv_rise;
  logic fv_fall;
  logic pix;
  logic line_d;
  logic line_end;
  logic starting;
  logic accumulating;
  logic in_roi;

  // Accumulator view for this cycle: cleared values when a frame starts
  logic [NUM_ROWS_WIDTH-1:0] row_b;
  logic [NUM_COLS_WIDTH-1:0] col_b;
  logic [NUM_COLS_WIDTH-1:0] first_len_b;
  logic                      first_seen_b;
  logic                      gerr_b;
  logic [SUM_WIDTH-1:0]      sum_b;
  logic [CNT_WIDTH-1:0]      cnt_b;
  logic [DATA_WIDTH-1:0]     min_b;
  logic [DATA_WIDTH-1:0]     max_b;

  logic [NUM_ROWS_WIDTH-1:0] rs_e;
  logic [NUM_ROWS_WIDTH-1:0] re_e;
  logic [NUM_COLS_WIDTH-1:0] cs_e;
  logic [NUM_COLS_WIDTH-1:0] ce_e;

  // Next accumulator values, also what gets latched at frame end
  logic [NUM_ROWS_WIDTH-1:0] row_nxt;
  logic [NUM_COLS_WIDTH-1:0] col_nxt;
  logic [NUM_COLS_WIDTH-1:0] first_len_nxt;
  logic                      first_seen_nxt;
  logic                      gerr_nxt;
  logic [SUM_WIDTH-1:0]      sum_nxt;
  logic [CNT_WIDTH-1:0]      cnt_nxt;
  logic [DATA_WIDTH-1:0]     min_nxt;
  logic [DATA_WIDTH-1:0]     max_nxt;

  assign fv_rise      = fv_s1 && !fv_d;
  assign fv_fall      = !fv_s1 && fv_d;
  assign pix          = fv_s1 && lv_s1;
  assign line_d       = fv_d && lv_d;
  // A qualified line ends when lv drops or when fv drops under a high lv (partial line).
  assign line_end     = line_d && !pix;
  assign starting     = (state == ST_ARMED) && fv_rise;
  assign accumulating = starting || (state == ST_FRAME);

  // Stage raw inputs; fv copies reset high so a frame still running when reset lifts never looks like a fresh rise
  always_ff @(posedge clk) begin
    if (reset) begin
      fv_s1  <= 1'b1;
      lv_s1  <= 1'b0;
      dat_s1 <= '0;
      fv_d   <= 1'b1;
      lv_d   <= 1'b0;
    end else begin
      fv_s1  <= fv;
      lv_s1  <= lv;
      dat_s1 <= dat;
      fv_d   <= fv_s1;
      lv_d   <= lv_s1;
    end
  end

  // Compute this cycle's index, geometry and ROI updates from the (possibly freshly cleared) accumulators
  always_comb begin
    row_b        = starting ? '0      : row_cnt;
    col_b        = starting ? '0      : col_cnt;
    first_len_b  = starting ? '0      : first_len;
    first_seen_b = starting ? 1'b0    : first_seen;
    gerr_b       = starting ? 1'b0    : gerr_acc;
    sum_b        = starting ? '0      : sum_acc;
    cnt_b        = starting ? '0      : cnt_acc;
    min_b        = starting ? DAT_MAX : min_acc;
    max_b        = starting ? '0      : max_acc;

    rs_e = starting ? roi_row_start : sh_row_start;
    re_e = starting ? roi_row_end   : sh_row_end;
    cs_e = starting ? roi_col_start : sh_col_start;
    ce_e = starting ? roi_col_end   : sh_col_end;

    in_roi = pix && (row_b >= rs_e) && (row_b < re_e) && (col_b >= cs_e) && (col_b < ce_e);

    row_nxt        = row_b;
    col_nxt        = col_b;
    first_len_nxt  = first_len_b;
    first_seen_nxt = first_seen_b;
    gerr_nxt       = gerr_b;
    sum_nxt        = sum_b;
    cnt_nxt        = cnt_b;
    min_nxt        = min_b;
    max_nxt        = max_b;

    if (pix && (col_b != COL_MAX)) begin
      col_nxt = col_b + NUM_COLS_WIDTH'(1);
    end

    // col_b holds the finished line's length here since pix is low on a line end
    if (line_end) begin
      col_nxt = '0;
      if (row_b != ROW_MAX) begin
        row_nxt = row_b + NUM_ROWS_WIDTH'(1);
      end
      if (!first_seen_b) begin
        first_len_nxt  = col_b;
        first_seen_nxt = 1'b1;
      end else if (col_b != first_len_b) begin
        gerr_nxt = 1'b1;
      end
    end

    if (in_roi) begin
      sum_nxt = sum_b + SUM_WIDTH'(dat_s1);
      cnt_nxt = cnt_b + CNT_WIDTH'(1);
      if (dat_s1 < min_b) begin
        min_nxt = dat_s1;
      end
      if (dat_s1 > max_b) begin
        max_nxt = dat_s1;
      end
    end
  end

  // Frame FSM: sync to a frame boundary, run the frame, leave on disable
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (!enable) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (!fv_s1) state <= ST_ARMED;
        ST_ARMED: if (fv_rise) state <= ST_FRAME;
        ST_FRAME: if (fv_fall) state <= ST_ARMED;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Accumulators advance only inside a measured frame; a disable discards them
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      row_cnt    <= '0;
      col_cnt    <= '0;
      first_len  <= '0;
      first_seen <= 1'b0;
      gerr_acc   <= 1'b0;
      sum_acc    <= '0;
      cnt_acc    <= '0;
      min_acc    <= DAT_MAX;
      max_acc    <= '0;
    end else if (accumulating) begin
      row_cnt    <= row_nxt;
      col_cnt    <= col_nxt;
      first_len  <= first_len_nxt;
      first_seen <= first_seen_nxt;
      gerr_acc   <= gerr_nxt;
      sum_acc    <= sum_nxt;
      cnt_acc    <= cnt_nxt;
      min_acc    <= min_nxt;
      max_acc    <= max_nxt;
    end
  end

  // Freeze ROI bounds at frame start so mid-frame register writes cannot split a frame
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_row_start <= '0;
      sh_row_end   <= '0;
      sh_col_start <= '0;
      sh_col_end   <= '0;
    end else if (enable && starting) begin
      sh_row_start <= roi_row_start;
      sh_row_end   <= roi_row_end;
      sh_col_start <= roi_col_start;
      sh_col_end   <= roi_col_end;
    end
  end

  // Latch results and pulse stats_valid on the staged fv fall of a measured frame
  always_ff @(posedge clk) begin
    if (reset) begin
      stats_valid <= 1'b0;
      frame_rows  <= '0;
      frame_cols  <= '0;
      geom_err    <= 1'b0;
      roi_sum     <= '0;
      roi_count   <= '0;
      roi_min     <= DAT_MAX;
      roi_max     <= '0;
      frame_count <= '0;
    end else begin
      stats_valid <= 1'b0;
      if (enable && (state == ST_FRAME) && fv_fall) begin
        stats_valid <= 1'b1;
        frame_rows  <= row_nxt;
        frame_cols  <= first_seen_nxt ? first_len_nxt : '0;
        geom_err    <= gerr_nxt;
        roi_sum     <= sum_nxt;
        roi_count   <= cnt_nxt;
        roi_min     <= min_nxt;
        roi_max     <= max_nxt;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imager_roi_stats.sv
// Directed bench for imager_roi_stats: drives imager-like frames, predicts each frame's
// results into a scoreboard queue and compares them when stats_valid pulses.
module tb_imager_roi_stats;

  localparam int DW = 10;
  localparam int RW = 12;
  localparam int CW = 12;
  localparam int SW = DW + RW + CW;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          fv;
  logic          lv;
  logic [DW-1:0] dat;
  logic [RW-1:0] roi_row_start;
  logic [RW-1:0] roi_row_end;
  logic [CW-1:0] roi_col_start;
  logic [CW-1:0] roi_col_end;
  logic          stats_valid;
  logic [RW-1:0] frame_rows;
  logic [CW-1:0] frame_cols;
  logic          geom_err;
  logic [SW-1:0] roi_sum;
  logic [DW-1:0] roi_min;
  logic [DW-1:0] roi_max;
  logic [RW+CW-1:0] roi_count;
  logic [15:0]   frame_count;

  typedef struct {
    int     rows;
    int     cols;
    int     gerr;
    longint sum;
    int     mn;
    int     mx;
    int     cnt;
    int     fc;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp;
  int   line_len[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   pulses = 0;
  int   exp_fc = 0;

  imager_roi_stats #(
    .DATA_WIDTH(DW), .NUM_ROWS_WIDTH(RW), .NUM_COLS_WIDTH(CW), .SUM_WIDTH(SW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .fv(fv), .lv(lv), .dat(dat),
    .roi_row_start(roi_row_start), .roi_row_end(roi_row_end),
    .roi_col_start(roi_col_start), .roi_col_end(roi_col_end),
    .stats_valid(stats_valid), .frame_rows(frame_rows), .frame_cols(frame_cols),
    .geom_err(geom_err), .roi_sum(roi_sum), .roi_min(roi_min), .roi_max(roi_max),
    .roi_count(roi_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 1: every pixel of a line equals its row; mode 2: dat = column + 2
  function automatic int pix_val(input int mode, input int r, input int c);
    if (mode == 1) return r & 1023;
    return (c + 2) & 1023;
  endfunction

  function automatic exp_t model(input int mode);
    exp_t e;
    e.rows = line_len.size();
    e.cols = line_len[0];
    e.gerr = 0;
    e.sum  = 0;
    e.mn   = 1023;
    e.mx   = 0;
    e.cnt  = 0;
    e.fc   = 0;
    for (int r = 0; r < line_len.size(); r++) begin
      if (line_len[r] != line_len[0]) e.gerr = 1;
      for (int c = 0; c < line_len[r]; c++) begin
        int v;
        v = pix_val(mode, r, c);
        if (r >= int'(roi_row_start) && r < int'(roi_row_end) &&
            c >= int'(roi_col_start) && c < int'(roi_col_end)) begin
          e.sum += v;
          e.cnt++;
          if (v < e.mn) e.mn = v;
          if (v > e.mx) e.mx = v;
        end
      end
    end
    return e;
  endfunction

  // disrupt: 0 none, 1 enable low for one cycle at row 1 col 3, 2 reset for two cycles from row 1 col 3
  task automatic drive_frame(input int mode, input int hblank, input int vblank, input int disrupt);
    if (disrupt == 0) begin
      exp_t e;
      e = model(mode);
      exp_fc++;
      e.fc = exp_fc;
      sb_q.push_back(e);
      last_exp = e;
      pushed++;
    end
    fv = 1'b1;
    lv = 1'b0;
    tick();
    for (int r = 0; r < line_len.size(); r++) begin
      for (int c = 0; c < line_len[r]; c++) begin
        lv     = 1'b1;
        dat    = DW'(pix_val(mode, r, c));
        enable = !(disrupt == 1 && r == 1 && c == 3);
        reset  = (disrupt == 2 && r == 1 && (c == 3 || c == 4));
        tick();
      end
      enable = 1'b1;
      reset  = 1'b0;
      lv     = 1'b0;
      dat    = '0;
      repeat (hblank) tick();
    end
    fv = 1'b0;
    repeat (vblank) tick();
  endtask

  task automatic set_roi(input int rs, input int re, input int cs, input int ce);
    roi_row_start = RW'(rs);
    roi_row_end   = RW'(re);
    roi_col_start = CW'(cs);
    roi_col_end   = CW'(ce);
  endtask

  // Scoreboard: pop the predicted frame on every stats_valid pulse
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && stats_valid === 1'b1) begin
      pulses++;
      if (sb_q.size() == 0) begin
        chk("unexpected_stats_valid", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("frame_rows",  64'(frame_rows),  64'(e.rows));
        chk("frame_cols",  64'(frame_cols),  64'(e.cols));
        chk("geom_err",    64'(geom_err),    64'(e.gerr));
        chk("roi_sum",     64'(roi_sum),     64'(e.sum));
        chk("roi_count",   64'(roi_count),   64'(e.cnt));
        chk("roi_min",     64'(roi_min),     64'(e.mn));
        chk("roi_max",     64'(roi_max),     64'(e.mx));
        chk("frame_count", 64'(frame_count), 64'(e.fc));
      end
    end
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    fv     = 1'b0;
    lv     = 1'b0;
    dat    = '0;
    set_roi(0, 4095, 0, 4095);
    repeat (3) tick();

    // Reset values
    @(negedge clk);
    chk("rst_stats_valid", 64'(stats_valid), 64'd0);
    chk("rst_frame_rows",  64'(frame_rows),  64'd0);
    chk("rst_frame_cols",  64'(frame_cols),  64'd0);
    chk("rst_geom_err",    64'(geom_err),    64'd0);
    chk("rst_roi_sum",     64'(roi_sum),     64'd0);
    chk("rst_roi_count",   64'(roi_count),   64'd0);
    chk("rst_roi_min",     64'(roi_min),     64'd1023);
    chk("rst_roi_max",     64'(roi_max),     64'd0);
    chk("rst_frame_count", 64'(frame_count), 64'd0);
    tick();
    reset = 1'b0;
    repeat (3) tick();

    // Mode 1 frames, full ROI; first pair back-to-back with one blank cycle
    line_len = '{8, 8, 8, 8};
    drive_frame(1, 4, 1, 0);
    drive_frame(1, 4, 1, 0);
    drive_frame(1, 4, 24, 0);
    chk("m1_roi_sum",     64'(roi_sum),     64'd48);
    chk("m1_roi_count",   64'(roi_count),   64'd32);
    chk("m1_roi_min",     64'(roi_min),     64'd0);
    chk("m1_roi_max",     64'(roi_max),     64'd3);
    chk("m1_frame_rows",  64'(frame_rows),  64'd4);
    chk("m1_frame_cols",  64'(frame_cols),  64'd8);
    chk("m1_frame_count", 64'(frame_count), 64'd3);

    // Mode 2, ROI rows 0..2, cols 1..3
    set_roi(0, 2, 1, 3);
    drive_frame(2, 4, 24, 0);
    chk("m2_roi_count", 64'(roi_count), 64'd4);
    chk("m2_roi_sum",   64'(roi_sum),   64'd14);
    chk("m2_roi_min",   64'(roi_min),   64'd3);
    chk("m2_roi_max",   64'(roi_max),   64'd4);

    // Inconsistent line lengths, then a clean frame
    set_roi(0, 4095, 0, 4095);
    line_len = '{8, 7, 8};
    drive_frame(1, 4, 24, 0);
    chk("geom_bad_err",  64'(geom_err),   64'd1);
    chk("geom_bad_cols", 64'(frame_cols), 64'd8);
    chk("geom_bad_rows", 64'(frame_rows), 64'd3);
    line_len = '{8, 8, 8, 8};
    drive_frame(1, 4, 24, 0);
    chk("geom_clean_err", 64'(geom_err), 64'd0);

    // Empty ROI on the column axis
    set_roi(0, 4095, 5, 5);
    drive_frame(2, 4, 24, 0);
    chk("empty_roi_count", 64'(roi_count),  64'd0);
    chk("empty_roi_sum",   64'(roi_sum),    64'd0);
    chk("empty_roi_min",   64'(roi_min),    64'd1023);
    chk("empty_roi_max",   64'(roi_max),    64'd0);
    chk("empty_rows",      64'(frame_rows), 64'd4);
    chk("empty_cols",      64'(frame_cols), 64'd8);

    // enable dropped for one cycle mid-frame: results hold, then next frame measured
    set_roi(1, 3, 0, 8);
    drive_frame(1, 4, 24, 1);
    chk("en_hold_count", 64'(frame_count), 64'(last_exp.fc));
    chk("en_hold_sum",   64'(roi_sum),     64'(last_exp.sum));
    chk("en_hold_min",   64'(roi_min),     64'(last_exp.mn));
    drive_frame(1, 4, 24, 0);
    chk("en_after_sum", 64'(roi_sum), 64'd24);

    // reset mid-frame, released while fv is high
    drive_frame(2, 4, 24, 2);
    exp_fc = 0;
    chk("rstmid_frame_count", 64'(frame_count), 64'd0);
    chk("rstmid_roi_sum",     64'(roi_sum),     64'd0);
    chk("rstmid_roi_min",     64'(roi_min),     64'd1023);
    drive_frame(2, 4, 24, 0);
    chk("rstmid_next_fc", 64'(frame_count), 64'd1);

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) tick();
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    chk("stats_pulse_count",  64'(pulses),      64'(pushed));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
